// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit bridging a CPU request port to a word-wide memory port
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake (ready only in IDLE)
//   req_we, req_size           store/load select, 0=byte 1=half 2=word 3=illegal
//   req_unsigned               zero-extend (1) or sign-extend (0) loads
//   req_addr, req_wdata        byte address and right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data (0 for stores/faults), fault flag
//   mem_valid                  combinational issue strobe in the accept cycle
//   mem_addr                   word-aligned memory address
//   mem_wdata, mem_wstrb       lane-aligned store data and byte strobes
//   mem_rdata, mem_rvalid      memory completion (loads and stores alike)

module load_store_unit #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rvalid
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Counter value during the last permitted WAIT cycle: the unit spends
    // exactly TIMEOUT_CYCLES cycles in WAIT before giving up.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Request fields kept for formatting the response after the memory answers
    logic [1:0] off_q;
    logic [1:0] size_q;
    logic       unsigned_q;
    logic       we_q;

    logic        accept;
    logic        misaligned;
    logic        out_of_range;
    logic        req_fault;
    logic [31:0] size_mask;
    logic [3:0]  base_strb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        out_of_range = (req_addr >> ADDR_WIDTH) != 32'd0;
        misaligned   = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
        req_fault    = (req_size == 2'd3) || misaligned || out_of_range;
    end

    // Faulting requests never reach memory
    assign mem_valid = accept && !req_fault;
    assign mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        size_mask = 32'h0000_00FF;
        base_strb = 4'b0001;
        case (req_size)
            2'd1: begin
                size_mask = 32'h0000_FFFF;
                base_strb = 4'b0011;
            end
            2'd2: begin
                size_mask = 32'hFFFF_FFFF;
                base_strb = 4'b1111;
            end
            default: begin
                size_mask = 32'h0000_00FF;
                base_strb = 4'b0001;
            end
        endcase
        if (req_we && (req_size != 2'd3)) begin
            mem_wstrb = base_strb << req_addr[1:0];
            mem_wdata = (req_wdata & size_mask) << {req_addr[1:0], 3'b000};
        end else begin
            mem_wstrb = 4'b0000;
            mem_wdata = 32'd0;
        end
    end

    // Lane extraction; halves are always 2-byte aligned here, so only off_q[1] matters
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'd0:    load_data = {{24{~unsigned_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_data = {{16{~unsigned_q & half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase
        if (we_q) begin
            load_data = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            case (state)
                ST_IDLE: begin
                    // mem_rvalid is deliberately not looked at here
                    if (accept) begin
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        we_q       <= req_we;
                        wait_cnt   <= '0;
                        state      <= req_fault ? ST_FAULT : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response arriving on the timeout cycle still completes normally
                    if (mem_rvalid) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end else if (wait_cnt == CNT_LAST) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    state      <= ST_IDLE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard testbench for load_store_unit

module tb_load_store_unit;

    localparam int AW = 16;
    localparam int TO = 15;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          req_valid    = 1'b0;
    logic          req_we       = 1'b0;
    logic [1:0]    req_size     = 2'd0;
    logic          req_unsigned = 1'b0;
    logic [31:0]   req_addr     = 32'd0;
    logic [31:0]   req_wdata    = 32'd0;
    logic [31:0]   mem_rdata    = 32'd0;
    logic          mem_rvalid   = 1'b0;
    logic          req_ready;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;

    load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [7:0] env_mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pulse must match the oldest expectation, in the expected cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got err=%b rdata=%h at cycle %0d, expected no response",
                             resp_err, resp_rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (resp_err !== e.err || resp_rdata !== e.rdata || cyc != e.due) begin
                        errors++;
                        $display("FAIL resp: got err=%b rdata=%h cycle=%0d expected err=%b rdata=%h cycle=%0d",
                                 resp_err, resp_rdata, cyc, e.err, e.rdata, e.due);
                    end
                end
            end
        end
    end

    // Issue one request; lat = WAIT cycle (1..TO) in which memory answers, 0 = never answers
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int lat);
        int          guard;
        int          n;
        int          off;
        int          acc;
        int          es;
        int          base;
        logic        fault;
        logic [63:0] m64;
        logic [63:0] d64;
        logic [31:0] val;
        logic [15:0] cap_addr;
        logic [3:0]  cap_strb;
        logic [31:0] cap_wdata;
        exp_t        e;

        guard = 0;
        while (!req_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_wait: got req_ready=0 after %0d cycles expected 1", guard);
            return;
        end

        n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off   = int'(addr % 4);
        fault = (sz == 2'd3) || ((addr % n) != 0) || ((addr >> AW) != 0);
        m64   = (64'd1 << (8 * n)) - 64'd1;

        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        #1;
        acc = cyc;
        check("mem_valid", 32'(mem_valid), fault ? 32'd0 : 32'd1);
        cap_addr  = mem_addr;
        cap_strb  = mem_wstrb;
        cap_wdata = mem_wdata;
        if (!fault) begin
            es  = we ? (((1 << n) - 1) << off) : 0;
            d64 = ({32'd0, wd} & m64) << (8 * off);
            check("mem_addr", 32'(mem_addr), addr & 32'h0000_FFFC);
            check("mem_wstrb", 32'(mem_wstrb), es);
            if (we) check("mem_wdata", mem_wdata, d64[31:0]);
        end

        e.err   = 1'b0;
        e.rdata = 32'd0;
        if (fault) begin
            e.err = 1'b1;
            e.due = acc + 2;
        end else if (lat == 0) begin
            e.err = 1'b1;
            e.due = acc + TO + 1;
        end else begin
            e.due = acc + lat + 1;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[int'(addr % 1024) + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[int'(addr % 1024) + i]) << (8 * i));
                if (!uns && n < 4 && val[8*n-1]) val = val | ~m64[31:0];
                e.rdata = val;
            end
        end
        exp_q.push_back(e);

        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        if (fault) begin
            check("fault_no_issue", 32'(mem_valid), 32'd0);
            mem_rvalid = 1'($urandom_range(0, 1));
            @(negedge clk);
            mem_rvalid = 1'b0;
            return;
        end

        base = int'(cap_addr[9:0]);
        for (int k = 1; k <= TO; k++) begin
            if (k == 1) check("wait_not_ready", 32'(req_ready), 32'd0);
            if (k == lat) begin
                mem_rdata  = {env_mem[base+3], env_mem[base+2], env_mem[base+1], env_mem[base]};
                mem_rvalid = 1'b1;
                for (int b = 0; b < 4; b++) if (cap_strb[b]) env_mem[base+b] = cap_wdata[8*b +: 8];
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (k == lat) break;
        end
        check("ready_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic [1:0]  sz;
        logic [31:0] addr;
        int          r;
        int          lat;

        for (int i = 0; i < 1024; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        env_mem[256] = 8'h78; env_mem[257] = 8'h56; env_mem[258] = 8'h34; env_mem[259] = 8'h12;
        ref_mem[256] = 8'h78; ref_mem[257] = 8'h56; ref_mem[258] = 8'h34; ref_mem[259] = 8'h12;
        env_mem[512] = 8'h44; env_mem[513] = 8'h33; env_mem[514] = 8'h22; env_mem[515] = 8'h11;
        ref_mem[512] = 8'h44; ref_mem[513] = 8'h33; ref_mem[514] = 8'h22; ref_mem[515] = 8'h11;

        repeat (3) @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 3);
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'd0, 1);
        env_mem[257] = 8'h86;
        ref_mem[257] = 8'h86;
        issue(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, 2);
        issue(1'b0, 2'd0, 1'b1, 32'h101, 32'd0, 2);
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'hDEAD_BEEF, 2);
        issue(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'd0, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'd0, 1);
        issue(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 1);
        issue(1'b1, 2'd1, 1'b0, 32'h203, 32'h1234, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, 0);
        issue(1'b0, 2'd0, 1'b1, 32'h105, 32'd0, TO);
        issue(1'b1, 2'd0, 1'b0, 32'h106, 32'hA5, TO);

        // Reset in the middle of WAIT: the access is dropped and the late answer ignored
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h100;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_resp_rdata", resp_rdata, 32'd0);
        check("midrst_resp_err", 32'(resp_err), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_mem_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_req_ready", 32'(req_ready), 32'd1);
        mem_rdata  = 32'hCAFE_F00D;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("postrst_no_resp", 32'(resp_valid), 32'd0);
            check("postrst_ready", 32'(req_ready), 32'd1);
        end

        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
            we = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            addr = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
                if (sz == 2'd2) addr = addr & 32'hFFFF_FFFC;
            end
            if ($urandom_range(0, 19) == 0) addr = addr | (32'($urandom_range(1, 65535)) << 16);
            lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, TO);
            issue(we, sz, 1'($urandom_range(0, 1)), addr, $urandom, lat);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, giving the memory byte-address width on the mem_* port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15, giving the maximum number of WAIT cycles before a fault response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: CPU access request.
REQ-006 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and faults.
REQ-014 SHALL have port resp_err, output, 1 bit: fault flag, qualified by resp_valid.
REQ-015 SHALL have the following memory-side ports:
- mem_valid, output, 1 bit.
- mem_addr, output, ADDR_WIDTH bits.
- mem_wdata, output, 32 bits.
- mem_wstrb, output, 4 bits.
- mem_rdata, input, 32 bits.
- mem_rvalid, input, 1 bit.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and FAULT; req_ready SHALL equal (state == IDLE).
REQ-017 SHALL accept a request when req_valid && req_ready at a rising edge.
REQ-018 SHALL classify an accepted request as faulting in any of these cases:
- req_size == 3.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- Out of range: req_addr[31:ADDR_WIDTH] != 0.
REQ-019 For a faulting request, SHALL drive mem_valid = 0 and transition IDLE -> FAULT; FAULT -> IDLE SHALL occur on the next edge, with resp_valid = 1, resp_err = 1 and resp_rdata = 0 in the cycle after the transition.
REQ-020 For a non-faulting accepted request, mem_valid SHALL be combinationally 1 in the accept cycle, driven only in IDLE, and the FSM SHALL go IDLE -> WAIT.
REQ-021 SHALL drive mem_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-022 For stores, mem_wstrb SHALL be:
- byte: 4'b0001 << addr[1:0].
- half: 4'b0011 << addr[1:0].
- word: 4'b1111.
REQ-023 For stores, mem_wdata SHALL be req_wdata shifted left by 8 * addr[1:0], with bits above the access size zeroed.
REQ-024 For loads, mem_wstrb SHALL be 0.
REQ-025 On accept, SHALL register addr[1:0], req_size, req_unsigned and req_we for response formatting.
REQ-026 In WAIT, on mem_rvalid the FSM SHALL go to IDLE and, on the next cycle, SHALL pulse resp_valid with resp_err = 0.
REQ-027 Load responses SHALL format the selected data as follows:
- Byte data: mem_rdata[8*off +: 8].
- Half data: mem_rdata[8*off +: 16].
- Extension: sign- or zero-extended to 32 bits per req_unsigned.
- Stores SHALL return resp_rdata = 0.
REQ-028 Every issued memory access, loads and stores alike, SHALL complete only on mem_rvalid; at most one access SHALL be outstanding.
REQ-029 A 5-bit-or-wider wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-030 If the counter reaches TIMEOUT_CYCLES without mem_rvalid, SHALL go WAIT -> IDLE and respond with resp_err = 1 and resp_rdata = 0.
REQ-031 If mem_rvalid arrives in the same cycle the timeout is reached, mem_rvalid SHALL win and produce a normal response.
REQ-032 mem_rvalid in IDLE or FAULT SHALL be ignored.
REQ-033 TIMEOUT_CYCLES SHALL exceed the memory response latency; the unit SHALL NOT track late responses.
REQ-034 The memory side SHALL see total latency = memory latency + 1 cycle from request accept to resp_valid.

Reset
REQ-035 While rst_n = 0, SHALL force state = IDLE, wait counter = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0 and the registered request fields = 0.
REQ-036 Reset asserted mid-WAIT SHALL abandon the access with no response; req_ready SHALL be 1 from the first edge after rst_n deasserts.

Verification
REQ-037 Word load: mem bytes 0x100..0x103 = 78 56 34 12, load word at 0x100 -> mem_addr = 0x100, mem_wstrb = 0; resp_rdata = 0x12345678, resp_err = 0, one pulse.
REQ-038 Byte loads: same data, signed byte load at 0x103 -> 0x00000012; mem byte 0x101 = 0x86: signed byte at 0x101 -> 0xFFFFFF86, unsigned -> 0x00000086.
REQ-039 Half store: store half 0xBEEF at 0x202 -> mem_addr = 0x200, mem_wstrb = 4'b1100, mem_wdata = 0xBEEF0000; word read-back at 0x200 -> 0xBEEFxxxx with the lower half unchanged.
REQ-040 Faults: word load at 0x101 -> mem_valid never asserted, resp_err = 1 two cycles after accept; load at 0x0001_0000 with ADDR_WIDTH = 16 -> resp_err = 1.
REQ-041 Timeout: hold mem_rvalid = 0 after issue -> resp_err = 1 after TIMEOUT_CYCLES WAIT cycles; req_ready = 1 on the following cycle.
REQ-042 Reset: rst_n pulsed low mid-WAIT -> no resp_valid; a later mem_rvalid is ignored; all outputs stay at reset values.
